// File: rtl/fb_pkg.sv
// Shared definitions for the feedback combiner: FSM state encoding,
// a constant-foldable ceil(log2) helper and the adder-tree width.
package fb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_FEEDBACK = 2'd2,
    ST_CONST    = 2'd3
  } fb_state_t;

  // ceil(log2(value)); usable in parameter context
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Width that holds N_CH channel terms plus the offset without wrapping
  function automatic int sum_w(input int in_w, input int n_ch);
    return in_w + clog2(n_ch + 1);
  endfunction

endpackage

// File: rtl/fb_sat.sv
// Output range limiter: reduces the wide channel sum to the DAC word.
// Build option FB_COMBINER_SAT_EN: defined -> clamp to the signed OUT_W
// range; undefined -> keep the low OUT_W bits (two's-complement wrap).
// The overflow flag is the same in both builds.
module fb_sat
  import fb_pkg::*;
#(
  parameter int SUM_W = 18,
  parameter int OUT_W = 13
) (
  input  logic signed [SUM_W-1:0] sum_in,
  output logic signed [OUT_W-1:0] sat_out,
  output logic                    ovf
);

  // Value fits OUT_W when every bit above the OUT_W sign bit equals it
  function automatic logic in_range(input logic signed [SUM_W-1:0] s);
    return (&s[SUM_W-1:OUT_W-1]) | ~(|s[SUM_W-1:OUT_W-1]);
  endfunction

  function automatic logic signed [OUT_W-1:0] limit(input logic signed [SUM_W-1:0] s);
`ifdef FB_COMBINER_SAT_EN
    if (in_range(s))
      return s[OUT_W-1:0];
    else if (s[SUM_W-1])
      return {1'b1, {(OUT_W-1){1'b0}}};
    else
      return {1'b0, {(OUT_W-1){1'b1}}};
`else
    return s[OUT_W-1:0];
`endif
  endfunction

  assign ovf     = ~in_range(sum_in);
  assign sat_out = limit(sum_in);

endmodule

// File: rtl/fb_combiner.sv
// Feedback combiner: sums enabled corrected-position channel terms plus a
// static offset and produces a registered DAC word three clocks after
// fb_cond. Slow-domain *_b controls pass through two-flop synchronisers.
// Build option FB_COMBINER_SAT_EN selects clamping instead of wrapping
// in fb_sat.
module fb_combiner
  import fb_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int IN_W  = 15,
  parameter int OUT_W = 13
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    store_strb,
  input  logic                    fb_cond,
  input  logic [N_CH*IN_W-1:0]    ch_data,
  input  logic [N_CH-1:0]         ch_oflow,
  input  logic [N_CH-1:0]         ch_en_b,
  input  logic signed [OUT_W-1:0] offset_b,
  input  logic                    const_dac_en_b,
  input  logic signed [OUT_W-1:0] const_dac_b,
  input  logic                    fb_en_b,
  input  logic                    oflow_clr,
  output logic signed [OUT_W-1:0] fb_sgnl,
  output logic                    fb_valid,
  output logic                    oflow,
  output logic                    oflow_sticky
);

  localparam int SUM_W  = sum_w(IN_W, N_CH);
  localparam int SYNC_W = N_CH + 2*OUT_W + 2;

  logic [SYNC_W-1:0]       sync_meta, sync_q;
  logic [N_CH-1:0]         ch_en_s;
  logic signed [OUT_W-1:0] offset_s, const_dac_s;
  logic                    const_dac_en_s, fb_en_s;

  logic signed [IN_W-1:0]  ch_p0 [N_CH];
  logic signed [OUT_W-1:0] off_p0;
  logic                    cof_p0, vld_p0;
  logic signed [SUM_W-1:0] sum_c, sum_p1;
  logic                    cof_p1, vld_p1;
  logic signed [OUT_W-1:0] sat_val;
  logic                    sat_ovf;

  fb_state_t state, state_nxt;
  logic      load_fb, load_const, clr_out, oflow_set;

  // Two-flop synchroniser; the reset keeps the chain out of shift-register primitives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= {ch_en_b, offset_b, const_dac_en_b, const_dac_b, fb_en_b};
      sync_q    <= sync_meta;
    end
  end

  assign {ch_en_s, offset_s, const_dac_en_s, const_dac_s, fb_en_s} = sync_q;

  // Stage 1: mask disabled channels and register the sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CH; k++) ch_p0[k] <= '0;
      off_p0 <= '0;
      cof_p0 <= 1'b0;
      vld_p0 <= 1'b0;
    end else begin
      if (fb_cond) begin
        for (int k = 0; k < N_CH; k++)
          ch_p0[k] <= ch_en_s[k] ? ch_data[k*IN_W +: IN_W] : '0;
        off_p0 <= offset_s;
        cof_p0 <= |(ch_oflow & ch_en_s);
      end
      vld_p0 <= fb_cond & store_strb;
    end
  end

  // Full-width sum of the masked channels and the sign-extended offset
  always_comb begin
    sum_c = {{(SUM_W-OUT_W){off_p0[OUT_W-1]}}, off_p0};
    for (int k = 0; k < N_CH; k++)
      sum_c = sum_c + {{(SUM_W-IN_W){ch_p0[k][IN_W-1]}}, ch_p0[k]};
  end

  // Stage 2: register the sum; a falling store_strb kills in-flight samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_p1 <= '0;
      cof_p1 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      sum_p1 <= sum_c;
      cof_p1 <= cof_p0;
      vld_p1 <= vld_p0 & store_strb;
    end
  end

  fb_sat #(
    .SUM_W (SUM_W),
    .OUT_W (OUT_W)
  ) u_sat (
    .sum_in  (sum_p1),
    .sat_out (sat_val),
    .ovf     (sat_ovf)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state; a mode change while running re-arms on the next fb_cond
  always_comb begin
    state_nxt = state;
    if (!store_strb) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:     state_nxt = ST_ARMED;
        ST_ARMED:    if (fb_cond) begin
                       if (const_dac_en_s)  state_nxt = ST_CONST;
                       else if (fb_en_s)    state_nxt = ST_FEEDBACK;
                     end
        ST_FEEDBACK: if (!fb_en_s || const_dac_en_s) state_nxt = ST_ARMED;
        ST_CONST:    if (!const_dac_en_s) state_nxt = ST_ARMED;
        default:     state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: what the output stage does this cycle
  always_comb begin
    load_fb    = (state == ST_FEEDBACK) && vld_p1 && store_strb;
    load_const = (state == ST_CONST)    && vld_p1 && store_strb;
    clr_out    = !store_strb || (state == ST_IDLE) || (state == ST_ARMED);
    oflow_set  = load_fb && (sat_ovf || cof_p1);
  end

  // Stage 3: output word, valid/overflow pulses and sticky overflow (set wins)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_sgnl      <= '0;
      fb_valid     <= 1'b0;
      oflow        <= 1'b0;
      oflow_sticky <= 1'b0;
    end else begin
      fb_valid <= load_fb | load_const;
      oflow    <= oflow_set;
      if (load_fb)         fb_sgnl <= sat_val;
      else if (load_const) fb_sgnl <= const_dac_s;
      else if (clr_out)    fb_sgnl <= '0;
      if (oflow_set)       oflow_sticky <= 1'b1;
      else if (oflow_clr)  oflow_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fb_combiner.sv
// Directed bench for fb_combiner with a latency-tagged scoreboard.
module tb_fb_combiner;
  import fb_pkg::*;

  localparam int N_CH  = 4;
  localparam int IN_W  = 15;
  localparam int OUT_W = 13;
`ifdef FB_COMBINER_SAT_EN
  localparam int OVF_EXP = 4095;
`else
  localparam int OVF_EXP = -192;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n, store_strb, fb_cond, const_dac_en_b, fb_en_b, oflow_clr;
  logic [N_CH*IN_W-1:0]    ch_data;
  logic [N_CH-1:0]         ch_oflow, ch_en_b;
  logic signed [OUT_W-1:0] offset_b, const_dac_b;
  logic signed [OUT_W-1:0] fb_sgnl;
  logic                    fb_valid, oflow, oflow_sticky;

  typedef struct {
    logic signed [OUT_W-1:0] v;
    logic                    o;
    int                      due;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fb_combiner #(.N_CH(N_CH), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .store_strb     (store_strb),
    .fb_cond        (fb_cond),
    .ch_data        (ch_data),
    .ch_oflow       (ch_oflow),
    .ch_en_b        (ch_en_b),
    .offset_b       (offset_b),
    .const_dac_en_b (const_dac_en_b),
    .const_dac_b    (const_dac_b),
    .fb_en_b        (fb_en_b),
    .oflow_clr      (oflow_clr),
    .fb_sgnl        (fb_sgnl),
    .fb_valid       (fb_valid),
    .oflow          (oflow),
    .oflow_sticky   (oflow_sticky)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] req);
    total++;
    assert (obs === req) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, req);
    end
  endtask

  // One clock; sample 1ns after the edge and retire scoreboard entries
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (fb_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", fb_valid, 0);
      end else begin
        e = q.pop_front();
        chk("latency", cyc, e.due);
        chk("fb_sgnl", fb_sgnl, e.v);
        chk("oflow", oflow, e.o);
      end
    end else begin
      if (q.size() != 0 && q[0].due == cyc) begin
        chk("missing_valid", fb_valid, 1);
        void'(q.pop_front());
      end
      chk("oflow_idle", oflow, 0);
    end
  endtask

  task automatic push(input int v, input logic o);
    exp_t e;
    e.v   = OUT_W'(v);
    e.o   = o;
    e.due = cyc + 3;
    q.push_back(e);
  endtask

  task automatic pulse(input int v, input logic o, input bit req_out);
    fb_cond = 1'b1;
    if (req_out) push(v, o);
    step();
    fb_cond = 1'b0;
  endtask

  task automatic set_ch(input int a, input int b, input int c, input int d);
    ch_data = {IN_W'(d), IN_W'(c), IN_W'(b), IN_W'(a)};
  endtask

  initial begin
    rst_n = 1'b0; store_strb = 1'b0; fb_cond = 1'b0; ch_data = '0; ch_oflow = '0;
    ch_en_b = '0; offset_b = '0; const_dac_en_b = 1'b0; const_dac_b = '0;
    fb_en_b = 1'b0; oflow_clr = 1'b0;
    repeat (3) step();
    chk("rst_fb_sgnl", fb_sgnl, 0);
    chk("rst_fb_valid", fb_valid, 0);
    chk("rst_sticky", oflow_sticky, 0);
    chk("rst_fsm", dut.state, ST_IDLE);
    rst_n = 1'b1;

    // nominal sum, all channels enabled
    fb_en_b = 1'b1; ch_en_b = 4'hF; offset_b = 13'sd10;
    repeat (4) step();
    store_strb = 1'b1;
    repeat (2) step();
    chk("fsm_armed", dut.state, ST_ARMED);
    set_ch(100, 200, -50, 25);
    pulse(285, 1'b0, 1'b1);
    repeat (4) step();
    chk("hold_285", fb_sgnl, 285);
    chk("fsm_feedback", dut.state, ST_FEEDBACK);

    // back-to-back samples
    fb_cond = 1'b1;
    set_ch(1, 2, 3, 4);         push(20, 1'b0);   step();
    set_ch(-100, -200, -300, -400); push(-990, 1'b0); step();
    fb_cond = 1'b0;
    repeat (4) step();

    // overflow, sticky, clear
    offset_b = '0;
    repeat (4) step();
    set_ch(2000, 2000, 2000, 2000);
    pulse(OVF_EXP, 1'b1, 1'b1);
    repeat (4) step();
    chk("sticky_set", oflow_sticky, 1);
    set_ch(100, 200, -50, 25);
    pulse(275, 1'b0, 1'b1);
    repeat (4) step();
    chk("sticky_hold", oflow_sticky, 1);
    oflow_clr = 1'b1; step(); oflow_clr = 1'b0;
    chk("sticky_clr", oflow_sticky, 0);

    // channel mask; upstream flag on a disabled then enabled channel
    offset_b = 13'sd10; ch_en_b = 4'b0101; ch_oflow = 4'b0010;
    repeat (4) step();
    pulse(60, 1'b0, 1'b1);
    repeat (4) step();
    ch_en_b = 4'hF;
    repeat (4) step();
    pulse(285, 1'b1, 1'b1);
    ch_oflow = '0;
    repeat (4) step();
    oflow_clr = 1'b1; step(); oflow_clr = 1'b0;
    chk("sticky_clr2", oflow_sticky, 0);

    // feedback disabled: output forced to zero, no valid
    fb_en_b = 1'b0;
    repeat (4) step();
    chk("fb_off_zero", fb_sgnl, 0);
    pulse(0, 1'b0, 1'b0);
    repeat (4) step();
    chk("fb_off_hold", fb_sgnl, 0);

    // constant DAC mode ignores channel data and never flags overflow
    const_dac_en_b = 1'b1; const_dac_b = -13'sd1234;
    repeat (4) step();
    set_ch(2000, 2000, 2000, 2000);
    pulse(-1234, 1'b0, 1'b1);
    pulse(-1234, 1'b0, 1'b1);
    repeat (4) step();
    chk("fsm_const", dut.state, ST_CONST);
    chk("const_no_sticky", oflow_sticky, 0);

    // store_strb falls one cycle after fb_cond
    const_dac_en_b = 1'b0; fb_en_b = 1'b1; set_ch(100, 200, -50, 25);
    repeat (4) step();
    pulse(285, 1'b0, 1'b1);
    repeat (4) step();
    chk("pre_fall", fb_sgnl, 285);
    pulse(0, 1'b0, 1'b0);
    store_strb = 1'b0;
    step();
    chk("fall_zero", fb_sgnl, 0);
    chk("fall_novalid", fb_valid, 0);
    chk("fall_fsm", dut.state, ST_IDLE);
    repeat (4) step();
    chk("fall_hold", fb_sgnl, 0);

    // asynchronous reset mid-pulse
    store_strb = 1'b1;
    repeat (2) step();
    ch_oflow = 4'b0001;
    pulse(285, 1'b1, 1'b1);
    ch_oflow = '0;
    repeat (4) step();
    chk("pre_rst_sgnl", fb_sgnl, 285);
    chk("pre_rst_sticky", oflow_sticky, 1);
    pulse(0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sgnl", fb_sgnl, 0);
    chk("arst_valid", fb_valid, 0);
    chk("arst_oflow", oflow, 0);
    chk("arst_sticky", oflow_sticky, 0);
    chk("arst_fsm", dut.state, ST_IDLE);
    repeat (4) step();
    rst_n = 1'b1;
    repeat (4) step();
    chk("sb_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
